// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter
// Merges fetch refill reads and data refill reads / write-backs onto the
// single memory access port. Grants are combinational, alternate on ties,
// and read returns are routed back through an in-order tag FIFO while the
// returned serial numbers are checked against an expected running count.
module memory_request_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int SERIAL_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 icReqValid,
  input  logic [ADDR_WIDTH-1:0]                icReqAddr,
  output logic                                 icReqReady,
  input  logic                                 dcReqValid,
  input  logic                                 dcReqWrite,
  input  logic [ADDR_WIDTH-1:0]                dcReqAddr,
  input  logic [DATA_WIDTH-1:0]                dcReqData,
  output logic                                 dcReqReady,
  output logic                                 icRespValid,
  output logic [DATA_WIDTH-1:0]                icRespData,
  output logic                                 dcRespValid,
  output logic [DATA_WIDTH-1:0]                dcRespData,
  output logic                                 dcWriteAck,
  output logic [ADDR_WIDTH-1:0]                memAccessAddr,
  output logic [DATA_WIDTH-1:0]                memAccessWriteData,
  output logic                                 memAccessRE,
  output logic                                 memAccessWE,
  input  logic                                 memAccessBusy,
  input  logic                                 memReadDataReady,
  input  logic [DATA_WIDTH-1:0]                memReadData,
  input  logic [SERIAL_WIDTH-1:0]              memReadSerial,
  input  logic                                 memWriteRespValid,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstandingReads,
  output logic                                 serialError
);

  // MAX_OUTSTANDING is a power of two (at least 2), so the pointers wrap
  // naturally and the occupancy counter needs one extra bit to reach "full".
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  // Tag values stored per outstanding read.
  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_DATA  = 1'b1;

  logic [MAX_OUTSTANDING-1:0] r_tags;
  logic [PTR_W-1:0]           r_wrPtr;
  logic [PTR_W-1:0]           r_rdPtr;
  logic [CNT_W-1:0]           r_count;
  logic [SERIAL_WIDTH-1:0]    r_expSerial;
  logic                       r_serialError;
  logic                       r_lastGrant;

  logic w_full;
  logic w_empty;
  logic w_icElig;
  logic w_dcElig;
  logic w_grantIc;
  logic w_grantDc;
  logic w_push;
  logic w_pop;
  logic w_popTag;
  logic w_serialBad;
  logic w_spurious;

  assign w_full   = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty  = (r_count == '0);
  assign w_popTag = r_tags[r_rdPtr];

  // Eligibility and round-robin tie break; everything is held off during reset
  // so no strobe or ready can leak out while the block is being cleared.
  always_comb begin
    w_icElig  = 1'b0;
    w_dcElig  = 1'b0;
    w_grantIc = 1'b0;
    w_grantDc = 1'b0;
    if (!rst) begin
      w_icElig = icReqValid && !memAccessBusy && !w_full;
      w_dcElig = dcReqValid && !memAccessBusy && (dcReqWrite || !w_full);
      // r_lastGrant = 1 means data won last time, so fetch takes the tie.
      w_grantIc = w_icElig && (!w_dcElig || r_lastGrant);
      w_grantDc = w_dcElig && !w_grantIc;
    end
  end

  assign w_push = w_grantIc || (w_grantDc && !dcReqWrite);
  assign w_pop  = !rst && memReadDataReady && !w_empty;

  assign w_serialBad = w_pop && (memReadSerial != r_expSerial);
  assign w_spurious  = !rst && memReadDataReady && w_empty;

  // Memory request payload and requester ready, driven from the grant.
  always_comb begin
    icReqReady         = 1'b0;
    dcReqReady         = 1'b0;
    memAccessRE        = 1'b0;
    memAccessWE        = 1'b0;
    memAccessAddr      = '0;
    memAccessWriteData = '0;
    if (w_grantIc) begin
      icReqReady    = 1'b1;
      memAccessRE   = 1'b1;
      memAccessAddr = icReqAddr;
    end else if (w_grantDc) begin
      dcReqReady    = 1'b1;
      memAccessAddr = dcReqAddr;
      if (dcReqWrite) begin
        memAccessWE        = 1'b1;
        memAccessWriteData = dcReqData;
      end else begin
        memAccessRE = 1'b1;
      end
    end
  end

  // Route a returning read to whichever requester sits at the FIFO head.
  always_comb begin
    icRespValid = 1'b0;
    icRespData  = '0;
    dcRespValid = 1'b0;
    dcRespData  = '0;
    if (w_pop) begin
      if (w_popTag == TAG_DATA) begin
        dcRespValid = 1'b1;
        dcRespData  = memReadData;
      end else begin
        icRespValid = 1'b1;
        icRespData  = memReadData;
      end
    end
  end

  assign dcWriteAck       = !rst && memWriteRespValid;
  assign outstandingReads = r_count;
  assign serialError      = r_serialError;

  // Tag FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tags  <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tags[r_wrPtr] <= w_grantDc ? TAG_DATA : TAG_FETCH;
        r_wrPtr         <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Expected serial advances only on returns that actually matched a tag;
  // the error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expSerial   <= '0;
      r_serialError <= 1'b0;
    end else begin
      if (w_pop) begin
        r_expSerial <= r_expSerial + SERIAL_WIDTH'(1);
      end
      if (w_serialBad || w_spurious) begin
        r_serialError <= 1'b1;
      end
    end
  end

  // Remember which port won the most recent grant for the tie break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGrant <= 1'b1;
    end else if (w_grantIc) begin
      r_lastGrant <= 1'b0;
    end else if (w_grantDc) begin
      r_lastGrant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Testbench for memory_request_arbiter: a table of single-cycle vectors with
// hand-computed expectations, followed by hand-written multi-cycle sequences
// for FIFO full, same-cycle push/pop, serial errors and asynchronous reset.
module tb_memory_request_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 4;
  localparam int MO = 8;

  logic          clk;
  logic          rst;
  logic          icReqValid;
  logic [AW-1:0] icReqAddr;
  logic          icReqReady;
  logic          dcReqValid;
  logic          dcReqWrite;
  logic [AW-1:0] dcReqAddr;
  logic [DW-1:0] dcReqData;
  logic          dcReqReady;
  logic          icRespValid;
  logic [DW-1:0] icRespData;
  logic          dcRespValid;
  logic [DW-1:0] dcRespData;
  logic          dcWriteAck;
  logic [AW-1:0] memAccessAddr;
  logic [DW-1:0] memAccessWriteData;
  logic          memAccessRE;
  logic          memAccessWE;
  logic          memAccessBusy;
  logic          memReadDataReady;
  logic [DW-1:0] memReadData;
  logic [SW-1:0] memReadSerial;
  logic          memWriteRespValid;
  logic [3:0]    outstandingReads;
  logic          serialError;

  int checks;
  int errors;

  memory_request_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SERIAL_WIDTH(SW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .icReqValid(icReqValid), .icReqAddr(icReqAddr), .icReqReady(icReqReady),
    .dcReqValid(dcReqValid), .dcReqWrite(dcReqWrite), .dcReqAddr(dcReqAddr),
    .dcReqData(dcReqData), .dcReqReady(dcReqReady),
    .icRespValid(icRespValid), .icRespData(icRespData),
    .dcRespValid(dcRespValid), .dcRespData(dcRespData),
    .dcWriteAck(dcWriteAck),
    .memAccessAddr(memAccessAddr), .memAccessWriteData(memAccessWriteData),
    .memAccessRE(memAccessRE), .memAccessWE(memAccessWE),
    .memAccessBusy(memAccessBusy),
    .memReadDataReady(memReadDataReady), .memReadData(memReadData),
    .memReadSerial(memReadSerial), .memWriteRespValid(memWriteRespValid),
    .outstandingReads(outstandingReads), .serialError(serialError)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          icValid;
    logic [AW-1:0] icAddr;
    logic          dcValid;
    logic          dcWrite;
    logic [AW-1:0] dcAddr;
    logic [DW-1:0] dcData;
    logic          busy;
    logic          rdy;
    logic [DW-1:0] rdData;
    logic [SW-1:0] serial;
    logic          wrResp;
    logic          eIcReady;
    logic          eDcReady;
    logic          eRe;
    logic          eWe;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eWdata;
    logic          eIcResp;
    logic [DW-1:0] eIcData;
    logic          eDcResp;
    logic [DW-1:0] eDcData;
    logic          eWrAck;
    logic [3:0]    eOut;
    logic          eErr;
  } vec_t;

  vec_t vecs[13];

  localparam logic [DW-1:0] DA5 = {4{32'hA5A5_A5A5}};
  localparam logic [DW-1:0] DWB = {4{32'h1234_5678}};

  function automatic vec_t idleVec();
    vec_t v;
    v.icValid = 0; v.icAddr = '0; v.dcValid = 0; v.dcWrite = 0; v.dcAddr = '0;
    v.dcData = '0; v.busy = 0; v.rdy = 0; v.rdData = '0; v.serial = '0; v.wrResp = 0;
    v.eIcReady = 0; v.eDcReady = 0; v.eRe = 0; v.eWe = 0; v.eAddr = '0; v.eWdata = '0;
    v.eIcResp = 0; v.eIcData = '0; v.eDcResp = 0; v.eDcData = '0; v.eWrAck = 0;
    v.eOut = '0; v.eErr = 0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    icReqValid = 0; icReqAddr = '0; dcReqValid = 0; dcReqWrite = 0; dcReqAddr = '0;
    dcReqData = '0; memAccessBusy = 0; memReadDataReady = 0; memReadData = '0;
    memReadSerial = '0; memWriteRespValid = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    icReqValid = v.icValid; icReqAddr = v.icAddr; dcReqValid = v.dcValid;
    dcReqWrite = v.dcWrite; dcReqAddr = v.dcAddr; dcReqData = v.dcData;
    memAccessBusy = v.busy; memReadDataReady = v.rdy; memReadData = v.rdData;
    memReadSerial = v.serial; memWriteRespValid = v.wrResp;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.icReady", i), icReqReady, v.eIcReady);
    checkOutput($sformatf("v%0d.dcReady", i), dcReqReady, v.eDcReady);
    checkOutput($sformatf("v%0d.RE", i), memAccessRE, v.eRe);
    checkOutput($sformatf("v%0d.WE", i), memAccessWE, v.eWe);
    checkOutput($sformatf("v%0d.addr", i), memAccessAddr, v.eAddr);
    checkOutput($sformatf("v%0d.wdata", i), memAccessWriteData, v.eWdata);
    checkOutput($sformatf("v%0d.icResp", i), icRespValid, v.eIcResp);
    checkOutput($sformatf("v%0d.icData", i), icRespData, v.eIcData);
    checkOutput($sformatf("v%0d.dcResp", i), dcRespValid, v.eDcResp);
    checkOutput($sformatf("v%0d.dcData", i), dcRespData, v.eDcData);
    checkOutput($sformatf("v%0d.wrAck", i), dcWriteAck, v.eWrAck);
    checkOutput($sformatf("v%0d.outstanding", i), outstandingReads, v.eOut);
    checkOutput($sformatf("v%0d.serialErr", i), serialError, v.eErr);
  endtask

  // Synchronous-looking reset pulse; memory model (the bench) is idled with it.
  task automatic doReset();
    @(negedge clk);
    clearInputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // Next cycle: inputs change right after the falling edge.
  task automatic step();
    @(negedge clk);
    clearInputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearInputs();
    rst = 1;

    // Vector table, starting from reset state.
    for (int i = 0; i < 13; i++) vecs[i] = idleVec();
    // v1: tie after reset goes to fetch
    vecs[1].icValid = 1; vecs[1].icAddr = 32'h200; vecs[1].dcValid = 1; vecs[1].dcAddr = 32'h300;
    vecs[1].eIcReady = 1; vecs[1].eRe = 1; vecs[1].eAddr = 32'h200;
    // v2: tie goes to data
    vecs[2].icValid = 1; vecs[2].icAddr = 32'h210; vecs[2].dcValid = 1; vecs[2].dcAddr = 32'h300;
    vecs[2].eDcReady = 1; vecs[2].eRe = 1; vecs[2].eAddr = 32'h300; vecs[2].eOut = 1;
    // v3: fetch again
    vecs[3].icValid = 1; vecs[3].icAddr = 32'h210; vecs[3].dcValid = 1; vecs[3].dcAddr = 32'h310;
    vecs[3].eIcReady = 1; vecs[3].eRe = 1; vecs[3].eAddr = 32'h210; vecs[3].eOut = 2;
    // v4: data again
    vecs[4].icValid = 1; vecs[4].icAddr = 32'h220; vecs[4].dcValid = 1; vecs[4].dcAddr = 32'h310;
    vecs[4].eDcReady = 1; vecs[4].eRe = 1; vecs[4].eAddr = 32'h310; vecs[4].eOut = 3;
    // v5: busy blocks everything; return serial 0 goes to fetch
    vecs[5].icValid = 1; vecs[5].icAddr = 32'h220; vecs[5].dcValid = 1; vecs[5].dcAddr = 32'h320;
    vecs[5].busy = 1; vecs[5].rdy = 1; vecs[5].rdData = 128'hD0; vecs[5].serial = 0;
    vecs[5].eIcResp = 1; vecs[5].eIcData = 128'hD0; vecs[5].eOut = 4;
    // v6: serial 1 goes to data
    vecs[6].rdy = 1; vecs[6].rdData = 128'hD1; vecs[6].serial = 1;
    vecs[6].eDcResp = 1; vecs[6].eDcData = 128'hD1; vecs[6].eOut = 3;
    // v7: serial 2 to fetch while a write-back is issued
    vecs[7].rdy = 1; vecs[7].rdData = 128'hD2; vecs[7].serial = 2;
    vecs[7].dcValid = 1; vecs[7].dcWrite = 1; vecs[7].dcAddr = 32'h400; vecs[7].dcData = DWB;
    vecs[7].eIcResp = 1; vecs[7].eIcData = 128'hD2; vecs[7].eDcReady = 1; vecs[7].eWe = 1;
    vecs[7].eAddr = 32'h400; vecs[7].eWdata = DWB; vecs[7].eOut = 2;
    // v8: serial 3 to data, write completion pulse
    vecs[8].rdy = 1; vecs[8].rdData = 128'hD3; vecs[8].serial = 3; vecs[8].wrResp = 1;
    vecs[8].eDcResp = 1; vecs[8].eDcData = 128'hD3; vecs[8].eWrAck = 1; vecs[8].eOut = 1;
    // v9: idle, drained
    // v10: single fetch at 0x100
    vecs[10].icValid = 1; vecs[10].icAddr = 32'h100;
    vecs[10].eIcReady = 1; vecs[10].eRe = 1; vecs[10].eAddr = 32'h100;
    // v11: return A5 to fetch while data read wins the tie
    vecs[11].icValid = 1; vecs[11].icAddr = 32'h110; vecs[11].dcValid = 1; vecs[11].dcAddr = 32'h500;
    vecs[11].rdy = 1; vecs[11].rdData = DA5; vecs[11].serial = 4;
    vecs[11].eDcReady = 1; vecs[11].eRe = 1; vecs[11].eAddr = 32'h500;
    vecs[11].eIcResp = 1; vecs[11].eIcData = DA5; vecs[11].eOut = 1;
    // v12: serial 5 to data; occupancy still 1 from the same-cycle push/pop
    vecs[12].rdy = 1; vecs[12].rdData = 128'hE5; vecs[12].serial = 5;
    vecs[12].eDcResp = 1; vecs[12].eDcData = 128'hE5; vecs[12].eOut = 1;

    // Reset state while rst is held, with requests pending.
    @(negedge clk);
    icReqValid = 1; dcReqValid = 1; memReadDataReady = 1;
    #1;
    checkOutput("rst.icReady", icReqReady, 1'b0);
    checkOutput("rst.RE", memAccessRE, 1'b0);
    checkOutput("rst.icResp", icRespValid, 1'b0);
    checkOutput("rst.outstanding", outstandingReads, 4'd0);
    @(negedge clk);
    clearInputs();
    rst = 0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Fill the FIFO; a read is then held while a write still goes through.
    doReset();
    for (int i = 0; i < 8; i++) begin
      clearInputs();
      icReqValid = 1; icReqAddr = 32'h1000 + 32'(i * 16);
      #1;
      checkOutput($sformatf("fill%0d.icReady", i), icReqReady, 1'b1);
      @(negedge clk);
    end
    icReqValid = 1; icReqAddr = 32'h2000; dcReqValid = 1; dcReqWrite = 1; dcReqAddr = 32'h3000;
    #1;
    checkOutput("full.outstanding", outstandingReads, 4'd8);
    checkOutput("full.icReady", icReqReady, 1'b0);
    checkOutput("full.dcWriteReady", dcReqReady, 1'b1);
    checkOutput("full.WE", memAccessWE, 1'b1);
    step();
    icReqValid = 1; icReqAddr = 32'h2000; memReadDataReady = 1; memReadData = 128'hF0;
    #1;
    checkOutput("fullRet.icReady", icReqReady, 1'b0);
    checkOutput("fullRet.icResp", icRespValid, 1'b1);
    step();
    icReqValid = 1; icReqAddr = 32'h2000; memAccessBusy = 1;
    #1;
    checkOutput("busy.icReady", icReqReady, 1'b0);
    checkOutput("busy.outstanding", outstandingReads, 4'd7);
    step();
    icReqValid = 1; icReqAddr = 32'h2000;
    #1;
    checkOutput("held.icReady", icReqReady, 1'b1);
    checkOutput("held.addr", memAccessAddr, 32'h2000);
    step();
    #1;
    checkOutput("refill.outstanding", outstandingReads, 4'd8);

    // Return and new grant in the same cycle at occupancy 3.
    doReset();
    icReqValid = 1; icReqAddr = 32'h10; dcReqValid = 1; dcReqAddr = 32'h20;
    step();
    icReqValid = 1; icReqAddr = 32'h11; dcReqValid = 1; dcReqAddr = 32'h20;
    step();
    icReqValid = 1; icReqAddr = 32'h11;
    step();
    dcReqValid = 1; dcReqAddr = 32'h30; memReadDataReady = 1; memReadSerial = 0; memReadData = 128'hA0;
    #1;
    checkOutput("pp.outstandingBefore", outstandingReads, 4'd3);
    checkOutput("pp.dcReady", dcReqReady, 1'b1);
    checkOutput("pp.icResp", icRespValid, 1'b1);
    step();
    memReadDataReady = 1; memReadSerial = 1; memReadData = 128'hA1;
    #1;
    checkOutput("pp.outstandingAfter", outstandingReads, 4'd3);
    checkOutput("pp.ret1.dcResp", dcRespValid, 1'b1);
    checkOutput("pp.ret1.dcData", dcRespData, 128'hA1);
    step();
    memReadDataReady = 1; memReadSerial = 2; memReadData = 128'hA2;
    #1;
    checkOutput("pp.ret2.icResp", icRespValid, 1'b1);
    checkOutput("pp.ret2.icData", icRespData, 128'hA2);
    step();
    memReadDataReady = 1; memReadSerial = 3; memReadData = 128'hA3;
    #1;
    checkOutput("pp.ret3.dcResp", dcRespValid, 1'b1);
    checkOutput("pp.ret3.icResp", icRespValid, 1'b0);
    step();
    #1;
    checkOutput("pp.drained", outstandingReads, 4'd0);
    checkOutput("pp.serialErr", serialError, 1'b0);

    // Serial mismatch: data still delivered, error sticky through traffic.
    doReset();
    icReqValid = 1; icReqAddr = 32'h40;
    step();
    memReadDataReady = 1; memReadSerial = 5; memReadData = 128'hBAD5;
    #1;
    checkOutput("ser.icResp", icRespValid, 1'b1);
    checkOutput("ser.icData", icRespData, 128'hBAD5);
    step();
    icReqValid = 1; icReqAddr = 32'h50;
    #1;
    checkOutput("ser.errSet", serialError, 1'b1);
    step();
    memReadDataReady = 1; memReadSerial = 1; memReadData = 128'h51;
    step();
    #1;
    checkOutput("ser.errSticky", serialError, 1'b1);

    // Spurious return with an empty FIFO.
    doReset();
    memReadDataReady = 1; memReadSerial = 0; memReadData = 128'h99;
    #1;
    checkOutput("spur.icResp", icRespValid, 1'b0);
    checkOutput("spur.dcResp", dcRespValid, 1'b0);
    step();
    #1;
    checkOutput("spur.errSet", serialError, 1'b1);
    checkOutput("spur.outstanding", outstandingReads, 4'd0);

    // Asynchronous reset between edges with two reads outstanding.
    icReqValid = 1; icReqAddr = 32'h60;
    step();
    icReqValid = 1; icReqAddr = 32'h70;
    step();
    icReqValid = 1; icReqAddr = 32'h80; dcReqValid = 1; dcReqWrite = 1; dcReqAddr = 32'h90;
    #1;
    checkOutput("arst.before", outstandingReads, 4'd2);
    checkOutput("arst.dcReadyBefore", dcReqReady, 1'b1);
    rst = 1;
    #1;
    checkOutput("arst.outstanding", outstandingReads, 4'd0);
    checkOutput("arst.serialErr", serialError, 1'b0);
    checkOutput("arst.icReady", icReqReady, 1'b0);
    checkOutput("arst.dcReady", dcReqReady, 1'b0);
    checkOutput("arst.WE", memAccessWE, 1'b0);
    checkOutput("arst.RE", memAccessRE, 1'b0);
    @(negedge clk);
    rst = 0;
    clearInputs();
    icReqValid = 1; icReqAddr = 32'hA0; dcReqValid = 1; dcReqAddr = 32'hB0;
    #1;
    checkOutput("arst.tieFetch", icReqReady, 1'b1);
    checkOutput("arst.tieAddr", memAccessAddr, 32'hA0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
